fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain.
- Grants one owner at a time for bursts of up to BURST words, gates transfers on FIFO full, and drives the FIFO's wen and wdata directly.
- Sits between requester blocks and the FIFO write side; the read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width, equal to FIFO width
- BURST, 4, max consecutive words per ownership (1..16)

Ports:
- wclk  input  1  write-domain clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req  input  NREQ  per-requester valid; data held stable while req=1 and gnt=0
- req_data  input  NREQ*WIDTH  packed data, requester i at bits [i*WIDTH +: WIDTH]
- full  input  1  FIFO full flag
- gnt  output  NREQ  one-hot ready; word accepted when req[i]&gnt[i] at the clock edge
- wen  output  1  FIFO write enable
- wdata  output  WIDTH  FIFO write data
- owner  output  $clog2(NREQ)  current owner index; valid when busy=1
- busy  output  1  1 in OWN state
- wr_count  output  16  total accepted words, saturates at 16'hFFFF

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, wr_count=0.
- Reset forces gnt=0, wen=0, wdata=0, busy=0 immediately, including mid-burst. Words not accepted are lost; requesters re-present them.
- FSM has two states, IDLE and OWN.
- Search: the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NREQ.
- IDLE: gnt=0, wen=0.
  - If any req is high, register owner = search result, clear burst_cnt, go to OWN.
  - Arbitration latency: 1 cycle from req to first gnt.
- OWN, combinational outputs:
  - gnt[owner] = !full; all other gnt bits are 0.
  - wen = req[owner] & !full.
  - wdata = req_data[owner] when wen=1, else 0.
  - The transfer is seen by the FIFO on the same edge (0-cycle datapath latency).
- OWN, transfer edge:
  - burst_cnt++ and wr_count++ (saturating).
  - Release when burst_cnt reaches BURST-1 on this transfer.
- OWN, owner has req[owner]=0: release with no transfer.
- Release:
  - rr_ptr = owner+1 (mod NREQ).
  - Re-search from the new rr_ptr in the same cycle, excluding the releasing owner unless it is the only requester.
  - If a candidate exists: stay in OWN, load the new owner, clear burst_cnt. No bubble between bursts.
  - If none: go to IDLE.
- full=1 in OWN: gnt=0, wen=0. Owner, burst_cnt and wr_count are held. There is no timeout, and ownership is kept across the full stall.
- full deasserting: transfers resume on the next edge with req[owner]=1.
- Requesters deasserting req mid-burst: legal; this releases ownership as above.
- A req change on a non-owner never affects the current owner.
- Only one gnt bit is ever high; wen never rises while full=1, so the FIFO overflow flag must never set through this block.
- Fairness: with all NREQ requesting continuously and full=0, ownership rotates 0,1,2,…,NREQ-1,0 and each owner gets exactly BURST words.

Decomposition:
- Package fifo_arb_pkg holds the state enum {IDLE, OWN} and a function that computes rotating priority from (req, rr_ptr) and returns the index plus a found flag.
- One natural sub-module: rr_pick (combinational rotating-priority encoder), instantiated twice: initial arbitration and release re-search.

Test Plan:
- Reset then req=4'b0001, data 8'hA5 held:
  - gnt[0] first high in cycle 2.
  - wen=1, wdata=A5 on each edge for 4 edges.
  - Then requester 0 alone is re-granted with no idle cycle.
  - wr_count increments by 1 per edge.
- req=4'b1111 constant, full=0, data[i]=8'h10+i:
  - FIFO receives 10×4, 11×4, 12×4, 13×4, then 10 again.
  - gnt is always one-hot.
- Owner 1 mid-burst (burst_cnt=2), full=1 for 5 cycles:
  - gnt=0, wen=0, owner=1 throughout.
  - After full=0, exactly 2 more words from requester 1, then owner moves to 2.
- req=4'b0101, requester 0 drops req after 1 word:
  - owner switches to 2 the next cycle.
  - rr_ptr=1, and requester 2 gets 4 words.
- rst=0 pulsed asynchronously mid-burst (between edges):
  - gnt, wen, busy go 0 immediately; wr_count=0.
  - After release, arbitration restarts from requester 0.
- Integrated with the FIFO (depth 8): 4 requesters, slow rclk, reader stalled:
  - wen stops at full after 8 words.
  - overflow stays 0.
  - A full drain gives read order equal to the grant order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... modulo n and return the first requester found.
  // The loop walks from the far end down so the nearest hit is written last.
  function automatic pick_t rr_search(input logic [MAX_REQ-1:0] req,
                                      input int ptr,
                                      input int n);
    pick_t res;
    int    pos;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      pos = ptr + k;
      if (pos >= n) pos = pos - n;
      if ((k < n) && req[pos[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first active request at or after ptr.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [MAX_REQ-1:0] req_wide;
  pick_t              pick_res;

  // Widen the request vector to the package width and run the search.
  always_comb begin
    req_wide             = '0;
    req_wide[NREQ-1:0]   = req;
    pick_res             = rr_search(req_wide, int'(ptr), NREQ);
    found                = pick_res.found;
    idx                  = IW'(pick_res.idx);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port: bursts of up to BURST words,
// stalls on full, and hands over to the next requester without a bubble.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic                    full,
  output logic [NREQ-1:0]         gnt,
  output logic                    wen,
  output logic [WIDTH-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [15:0]             wr_count
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] burst_cnt;
  logic [IW-1:0] next_ptr;
  logic          idle_found;
  logic [IW-1:0] idle_idx;
  logic          rel_found;
  logic [IW-1:0] rel_idx;
  logic          last_word;
  logic          release_now;

  // Initial arbitration searches from the stored round-robin pointer.
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_idle (
    .req   (req),
    .ptr   (rr_ptr),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Release search starts one past the owner, so the owner comes last and is
  // only re-picked when nobody else is asking.
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_rel (
    .req   (req),
    .ptr   (next_ptr),
    .found (rel_found),
    .idx   (rel_idx)
  );

  // Pointer wrap, burst-end detect and release decision for the current owner.
  always_comb begin
    next_ptr    = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    last_word   = (burst_cnt == CW'(BURST - 1));
    release_now = (state == OWN) && (!req[owner] || (wen && last_word));
  end

  // Write-port outputs follow the owner combinationally so the FIFO sees the
  // word on the same edge it is accepted.
  always_comb begin
    gnt   = '0;
    wen   = 1'b0;
    wdata = '0;
    busy  = (state == OWN);
    if ((state == OWN) && !full) begin
      gnt[owner] = 1'b1;
      wen        = req[owner];
    end
    if (wen) wdata = req_data[owner*WIDTH +: WIDTH];
  end

  // Ownership FSM, burst counter and saturating accepted-word counter.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wr_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_found) begin
            owner     <= idle_idx;
            burst_cnt <= '0;
            state     <= OWN;
          end
        end
        OWN: begin
          if (wen) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end
          if (release_now) begin
            rr_ptr    <= next_ptr;
            burst_cnt <= '0;
            if (rel_found) owner <= rel_idx;
            else           state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
